hc_msi_trio: RTL and testbench

- Clocked wrapper around three classic 74HC-series MSI functions with independent inputs and outputs:
  - 3-to-8 decoder (74HC138 behaviour).
  - 8-to-3 priority encoder (74HC148 behaviour).
  - 4-to-1 multiplexer with strobe (74HC153 behaviour).
- Each function is evaluated combinationally, and its result is captured in output registers.
- Sits as glue logic between a control FSM and downstream select/display paths.

---
 rtl/hc_msi_pkg.sv | 18 +
 rtl/hc_prio_enc8.sv | 47 ++++
 rtl/hc_msi_trio.sv | 75 +++++++
 tb/tb_hc_msi_trio.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hc_msi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hc_msi_pkg
// Brief    : Shared widths and idle/reset values for the hc_msi_trio slice.
// Revision : 1.0 - initial release
// ============================================================================
package hc_msi_pkg;

    localparam int DEC_W = 8;
    localparam int SEL_W = 3;
    localparam int MUX_W = 4;

    localparam logic [DEC_W-1:0] DEC_IDLE = 8'hFF;
    localparam logic [SEL_W-1:0] ENC_IDLE = 3'b111;
    localparam logic             MUX_IDLE = 1'b0;

endpackage : hc_msi_pkg
`default_nettype wire

// File: rtl/hc_prio_enc8.sv
`default_nettype none
// ============================================================================
// Module   : hc_prio_enc8
// Brief    : Combinational 8-to-3 priority encoder core, 74HC148 behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module hc_prio_enc8
    import hc_msi_pkg::*;
(
    input  logic [DEC_W-1:0] i_req,
    input  logic             i_ei,
    output logic [SEL_W-1:0] o_out,
    output logic             o_eo,
    output logic             o_gs
);

    logic             w_any;
    logic [SEL_W-1:0] w_idx;

    // Ascending scan so the highest active-low request overwrites lower ones.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int i = 0; i < DEC_W; i++) begin
            if (!i_req[i]) begin
                w_any = 1'b1;
                w_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        o_out = ENC_IDLE;
        o_eo  = 1'b1;
        o_gs  = 1'b1;
        if (!i_ei) begin
            if (w_any) begin
                o_out = ~w_idx;
                o_gs  = 1'b0;
            end else begin
                o_eo  = 1'b0;
            end
        end
    end

endmodule : hc_prio_enc8
`default_nettype wire

// File: rtl/hc_msi_trio.sv
`default_nettype none
// ============================================================================
// Module   : hc_msi_trio
// Brief    : Registered 74HC138 decoder, 74HC148 encoder and 74HC153 mux.
// Revision : 1.0 - initial release
// ============================================================================
module hc_msi_trio
    import hc_msi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       dec_e,
    input  logic [SEL_W-1:0] dec_a,
    output logic [DEC_W-1:0] dec_y,
    input  logic [DEC_W-1:0] enc_in,
    input  logic             enc_ei,
    output logic [SEL_W-1:0] enc_out,
    output logic             enc_eo,
    output logic             enc_gs,
    input  logic [MUX_W-1:0] mux_in,
    input  logic [1:0]       mux_sel,
    input  logic             mux_ei,
    output logic             mux_out
);

    logic             w_dec_en;
    logic [DEC_W-1:0] w_dec_y;
    logic [SEL_W-1:0] w_enc_out;
    logic             w_enc_eo;
    logic             w_enc_gs;
    logic             w_mux_out;

    logic [DEC_W-1:0] r_dec_y;
    logic [SEL_W-1:0] r_enc_out;
    logic             r_enc_eo;
    logic             r_enc_gs;
    logic             r_mux_out;

    // Pure AND form: any known disabling enable bit forces FF even if others are X.
    assign w_dec_en  = dec_e[2] & ~dec_e[1] & ~dec_e[0];
    assign w_dec_y   = ~({DEC_W{w_dec_en}} & (DEC_W'(1) << dec_a));
    assign w_mux_out = ~mux_ei & mux_in[mux_sel];

    hc_prio_enc8 u_prio_enc8 (
        .i_req (enc_in),
        .i_ei  (enc_ei),
        .o_out (w_enc_out),
        .o_eo  (w_enc_eo),
        .o_gs  (w_enc_gs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_y   <= DEC_IDLE;
            r_enc_out <= ENC_IDLE;
            r_enc_eo  <= 1'b1;
            r_enc_gs  <= 1'b1;
            r_mux_out <= MUX_IDLE;
        end else begin
            r_dec_y   <= w_dec_y;
            r_enc_out <= w_enc_out;
            r_enc_eo  <= w_enc_eo;
            r_enc_gs  <= w_enc_gs;
            r_mux_out <= w_mux_out;
        end
    end

    assign dec_y   = r_dec_y;
    assign enc_out = r_enc_out;
    assign enc_eo  = r_enc_eo;
    assign enc_gs  = r_enc_gs;
    assign mux_out = r_mux_out;

endmodule : hc_msi_trio
`default_nettype wire

// File: tb/tb_hc_msi_trio.sv
`default_nettype none
// ============================================================================
// Module   : tb_hc_msi_trio
// Brief    : Self-checking bench for hc_msi_trio against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hc_msi_trio;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dec_e;
    logic [2:0] dec_a;
    logic [7:0] dec_y;
    logic [7:0] enc_in;
    logic       enc_ei;
    logic [2:0] enc_out;
    logic       enc_eo;
    logic       enc_gs;
    logic [3:0] mux_in;
    logic [1:0] mux_sel;
    logic       mux_ei;
    logic       mux_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] got;
    logic [13:0] exp_v;

    localparam logic [13:0] IDLE_V = {8'hFF, 3'b111, 1'b1, 1'b1, 1'b0};

    hc_msi_trio dut (
        .clk     (clk),
        .rst     (rst),
        .dec_e   (dec_e),
        .dec_a   (dec_a),
        .dec_y   (dec_y),
        .enc_in  (enc_in),
        .enc_ei  (enc_ei),
        .enc_out (enc_out),
        .enc_eo  (enc_eo),
        .enc_gs  (enc_gs),
        .mux_in  (mux_in),
        .mux_sel (mux_sel),
        .mux_ei  (mux_ei),
        .mux_out (mux_out)
    );

    always #5 clk = ~clk;

    assign got = {dec_y, enc_out, enc_eo, enc_gs, mux_out};

    // Reference built straight from the datasheet rules: {dec_y, enc_out, eo, gs, mux_out}.
    function automatic logic [13:0] model(input logic r, input logic [2:0] e, input logic [2:0] a,
                                          input logic [7:0] req, input logic ei,
                                          input logic [3:0] mi, input logic [1:0] ms, input logic me);
        logic [7:0] y;
        logic [2:0] o;
        logic       eo, gs, m;
        int         n;
        if (r) return IDLE_V;
        y = 8'hFF;
        if (e == 3'b100) y[a] = 1'b0;
        n = -1;
        for (int k = 7; k >= 0; k--) begin
            if (n < 0 && req[k] == 1'b0) n = k;
        end
        if (ei) begin
            o = 3'b111; eo = 1'b1; gs = 1'b1;
        end else if (n < 0) begin
            o = 3'b111; eo = 1'b0; gs = 1'b1;
        end else begin
            o = 3'(7 - n); eo = 1'b1; gs = 1'b0;
        end
        m = me ? 1'b0 : mi[ms];
        return {y, o, eo, gs, m};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            dec_e = 3'b100; dec_a = 3'($urandom_range(0, 7));
            enc_in = 8'($urandom); enc_ei = 1'b0;
            mux_in = 4'hF; mux_sel = 2'($urandom_range(0, 3)); mux_ei = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (got !== IDLE_V) begin
                n_fail++;
                $display("FAIL reset cyc%0d got=%h exp=%h", c, got, IDLE_V);
            end
        end
        rst = 1'b0;
        dec_e = 3'b100; dec_a = 3'd2; enc_in = 8'hEF; enc_ei = 1'b0;
        mux_in = 4'b0100; mux_sel = 2'd2; mux_ei = 1'b0;
        exp_v = model(1'b0, dec_e, dec_a, enc_in, enc_ei, mux_in, mux_sel, mux_ei);
        @(posedge clk); #1;
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_decoder();
        logic [2:0] dis [3];
        dis[0] = 3'bxx1; dis[1] = 3'bx1x; dis[2] = 3'b0xx;
        for (int k = 0; k < 3; k++) begin
            dec_e = dis[k]; dec_a = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            n_checks++;
            if (dec_y !== 8'hFF) begin
                n_fail++;
                $display("FAIL dec_disable%0d got=%h exp=ff", k, dec_y);
            end
        end
        for (int a = 0; a < 8; a++) begin
            dec_e = 3'b100; dec_a = 3'(a);
            exp_v = model(1'b0, dec_e, dec_a, enc_in, enc_ei, mux_in, mux_sel, mux_ei);
            @(posedge clk); #1;
            n_checks++;
            if (dec_y !== exp_v[13:6]) begin
                n_fail++;
                $display("FAIL dec_sel%0d got=%h exp=%h", a, dec_y, exp_v[13:6]);
            end
        end
    endtask

    task automatic test_encoder();
        logic [7:0] pat [3];
        pat[0] = 8'b0101_1110; pat[1] = 8'b1101_1110; pat[2] = 8'hFF;
        for (int ei = 1; ei >= 0; ei--) begin
            for (int k = 0; k < 8; k++) begin
                enc_ei = 1'(ei); enc_in = ~(8'h01 << k);
                exp_v = model(1'b0, dec_e, dec_a, enc_in, enc_ei, mux_in, mux_sel, mux_ei);
                @(posedge clk); #1;
                n_checks++;
                if (got[5:1] !== exp_v[5:1]) begin
                    n_fail++;
                    $display("FAIL enc_walk ei=%0d k=%0d got=%b exp=%b", ei, k, got[5:1], exp_v[5:1]);
                end
            end
        end
        for (int p = 0; p < 3; p++) begin
            enc_ei = 1'b0; enc_in = pat[p];
            exp_v = model(1'b0, dec_e, dec_a, enc_in, enc_ei, mux_in, mux_sel, mux_ei);
            @(posedge clk); #1;
            n_checks++;
            if (got[5:1] !== exp_v[5:1]) begin
                n_fail++;
                $display("FAIL enc_prio in=%b got=%b exp=%b", enc_in, got[5:1], exp_v[5:1]);
            end
        end
    endtask

    task automatic test_mux();
        for (int me = 0; me < 2; me++) begin
            for (int s = 0; s < 4; s++) begin
                mux_in = 4'b1010; mux_sel = 2'(s); mux_ei = 1'(me);
                exp_v = model(1'b0, dec_e, dec_a, enc_in, enc_ei, mux_in, mux_sel, mux_ei);
                @(posedge clk); #1;
                n_checks++;
                if (mux_out !== exp_v[0]) begin
                    n_fail++;
                    $display("FAIL mux ei=%0d sel=%0d got=%b exp=%b", me, s, mux_out, exp_v[0]);
                end
            end
        end
    endtask

    task automatic test_concurrent();
        for (int c = 0; c < 100; c++) begin
            rst     = (c == 50);
            dec_e   = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom);
            dec_a   = 3'($urandom);
            enc_in  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            enc_ei  = ($urandom_range(0, 3) == 0);
            mux_in  = 4'($urandom);
            mux_sel = 2'($urandom);
            mux_ei  = ($urandom_range(0, 3) == 0);
            exp_v = model(rst, dec_e, dec_a, enc_in, enc_ei, mux_in, mux_sel, mux_ei);
            @(posedge clk); #1;
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc%0d got=%h exp=%h", c, got, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        dec_e = 3'b000; dec_a = 3'd0; enc_in = 8'hFF; enc_ei = 1'b1;
        mux_in = 4'h0; mux_sel = 2'd0; mux_ei = 1'b1;
        test_reset();
        test_decoder();
        test_encoder();
        test_mux();
        test_concurrent();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hc_msi_trio
`default_nettype wire
